// File: rtl/sdram_arbiter.sv
//-----------------------------------------------------------------------------
// Module      : sdram_arbiter
// Description : Two-port round-robin arbiter and transaction sequencer in
//               front of the SDRAM controller. Port 0 issues CPU single-word
//               reads/writes, port 1 issues display burst reads. The granted
//               command is latched onto the controller inputs, a one-cycle
//               start strobe is issued, and the controller busy/ready
//               handshake is tracked. A watchdog flags a silent controller.
// Ports       : clk, rst (sync, active-low)
//               i_p0_*  : CPU request/command; o_p0_ack/done/rdata
//               i_p1_*  : burst request/address; o_p1_ack/done/busy/rdata
//               o_mc_*  : controller command outputs
//               i_mc_*  : controller read data and status
//               o_err   : sticky watchdog error
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module sdram_arbiter #(
   parameter int BUSY_TIMEOUT = 4,
   parameter int DONE_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_p0_req,
   input  logic        i_p0_we,
   input  logic [24:0] i_p0_addr,
   input  logic [15:0] i_p0_wdata,
   output logic        o_p0_ack,
   output logic        o_p0_done,
   output logic [15:0] o_p0_rdata,
   input  logic        i_p1_req,
   input  logic [24:0] i_p1_addr,
   output logic        o_p1_ack,
   output logic        o_p1_done,
   output logic        o_p1_busy,
   output logic [15:0] o_p1_rdata,
   output logic        o_mc_start,
   output logic        o_mc_write_en,
   output logic        o_mc_burst_en,
   output logic [24:0] o_mc_addr,
   output logic [15:0] o_mc_data_in,
   input  logic [15:0] i_mc_data_out,
   input  logic        i_mc_data_ready,
   input  logic        i_mc_mem_ready,
   output logic        o_err
);

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_IDLE      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_FINISH    = 3'd4
   } state_t;

   localparam int CNT_MAX = (BUSY_TIMEOUT > DONE_TIMEOUT) ? BUSY_TIMEOUT : DONE_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   // The counter reads N-1 on the edge that completes the N-th waiting cycle.
   localparam logic [CNT_W-1:0] c_busy_lim = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_done_lim = CNT_W'(DONE_TIMEOUT - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_last_grant, w_last_nxt;
   logic             r_owner, w_owner_nxt;
   logic             r_p0_ack, w_p0_ack_nxt;
   logic             r_p1_ack, w_p1_ack_nxt;
   logic             r_p0_done, w_p0_done_nxt;
   logic             r_p1_done, w_p1_done_nxt;
   logic             r_p1_busy, w_p1_busy_nxt;
   logic             r_mc_start, w_start_nxt;
   logic             r_mc_we, w_we_nxt;
   logic             r_mc_burst, w_burst_nxt;
   logic [24:0]      r_mc_addr, w_addr_nxt;
   logic [15:0]      r_mc_din, w_din_nxt;
   logic [15:0]      r_p0_rdata, w_rdata_nxt;
   logic             r_err, w_err_nxt;
   logic             w_gnt;
   logic             w_finish;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_INIT;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_p0_ack     <= 1'b0;
         r_p1_ack     <= 1'b0;
         r_p0_done    <= 1'b0;
         r_p1_done    <= 1'b0;
         r_p1_busy    <= 1'b0;
         r_mc_start   <= 1'b0;
         r_mc_we      <= 1'b0;
         r_mc_burst   <= 1'b0;
         r_mc_addr    <= '0;
         r_mc_din     <= '0;
         r_p0_rdata   <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_last_grant <= w_last_nxt;
         r_owner      <= w_owner_nxt;
         r_p0_ack     <= w_p0_ack_nxt;
         r_p1_ack     <= w_p1_ack_nxt;
         r_p0_done    <= w_p0_done_nxt;
         r_p1_done    <= w_p1_done_nxt;
         r_p1_busy    <= w_p1_busy_nxt;
         r_mc_start   <= w_start_nxt;
         r_mc_we      <= w_we_nxt;
         r_mc_burst   <= w_burst_nxt;
         r_mc_addr    <= w_addr_nxt;
         r_mc_din     <= w_din_nxt;
         r_p0_rdata   <= w_rdata_nxt;
         r_err        <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_last_nxt    = r_last_grant;
      w_owner_nxt   = r_owner;
      w_p0_ack_nxt  = 1'b0;
      w_p1_ack_nxt  = 1'b0;
      w_p0_done_nxt = 1'b0;
      w_p1_done_nxt = 1'b0;
      w_p1_busy_nxt = r_p1_busy;
      w_start_nxt   = 1'b0;
      w_we_nxt      = r_mc_we;
      w_burst_nxt   = r_mc_burst;
      w_addr_nxt    = r_mc_addr;
      w_din_nxt     = r_mc_din;
      w_rdata_nxt   = r_p0_rdata;
      w_err_nxt     = r_err;
      w_gnt         = 1'b0;
      w_finish      = 1'b0;

      case (r_state)
         ST_INIT: begin
            if (i_mc_mem_ready) w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (i_p0_req || i_p1_req) begin
               // On a tie the port that was not served last wins.
               w_gnt       = (i_p0_req && i_p1_req) ? ~r_last_grant : i_p1_req;
               w_owner_nxt = w_gnt;
               w_start_nxt = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_WAIT_BUSY;
               if (!w_gnt) begin
                  w_p0_ack_nxt = 1'b1;
                  w_we_nxt     = i_p0_we;
                  w_burst_nxt  = 1'b0;
                  w_addr_nxt   = i_p0_addr;
                  w_din_nxt    = i_p0_wdata;
               end else begin
                  w_p1_ack_nxt  = 1'b1;
                  w_p1_busy_nxt = 1'b1;
                  w_we_nxt      = 1'b0;
                  w_burst_nxt   = 1'b1;
                  w_addr_nxt    = i_p1_addr;
                  w_din_nxt     = '0;
               end
            end
         end
         ST_WAIT_BUSY: begin
            if (!i_mc_data_ready) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_WAIT_DONE;
            end else if (r_cnt == c_busy_lim) begin
               w_err_nxt = 1'b1;
               w_finish  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (i_mc_data_ready) begin
               w_finish = 1'b1;
               // mc write enable still holds the owner's command here.
               if (!r_owner && !r_mc_we) w_rdata_nxt = i_mc_data_out;
            end else if (r_cnt == c_done_lim) begin
               w_err_nxt = 1'b1;
               w_finish  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_FINISH: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase

      // Completion is registered on the edge that enters FINISH so the done
      // pulse occupies the FINISH cycle itself.
      if (w_finish) begin
         w_state_nxt   = ST_FINISH;
         w_p0_done_nxt = ~r_owner;
         w_p1_done_nxt = r_owner;
         w_p1_busy_nxt = 1'b0;
         w_last_nxt    = r_owner;
      end
   end

   assign o_p0_ack      = r_p0_ack;
   assign o_p0_done     = r_p0_done;
   assign o_p0_rdata    = r_p0_rdata;
   assign o_p1_ack      = r_p1_ack;
   assign o_p1_done     = r_p1_done;
   assign o_p1_busy     = r_p1_busy;
   assign o_p1_rdata    = i_mc_data_out;
   assign o_mc_start    = r_mc_start;
   assign o_mc_write_en = r_mc_we;
   assign o_mc_burst_en = r_mc_burst;
   assign o_mc_addr     = r_mc_addr;
   assign o_mc_data_in  = r_mc_din;
   assign o_err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
//-----------------------------------------------------------------------------
// Module      : tb_sdram_arbiter
// Description : Self-checking bench for sdram_arbiter. A transaction-level
//               model (round-robin owner, sticky error, word memory behind
//               the controller) predicts grants, latencies and read data.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_sdram_arbiter;

   localparam int BUSY_TO = 4;
   localparam int DONE_TO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_p0_req, i_p0_we, i_p1_req;
   logic [24:0] i_p0_addr, i_p1_addr;
   logic [15:0] i_p0_wdata;
   logic        o_p0_ack, o_p0_done, o_p1_ack, o_p1_done, o_p1_busy;
   logic [15:0] o_p0_rdata, o_p1_rdata;
   logic        o_mc_start, o_mc_write_en, o_mc_burst_en;
   logic [24:0] o_mc_addr;
   logic [15:0] o_mc_data_in;
   logic [15:0] i_mc_data_out;
   logic        i_mc_data_ready, i_mc_mem_ready;
   logic        o_err;

   always #5 clk = ~clk;

   sdram_arbiter #(.BUSY_TIMEOUT(BUSY_TO), .DONE_TIMEOUT(DONE_TO)) u_dut (
      .clk(clk), .rst(rst),
      .i_p0_req(i_p0_req), .i_p0_we(i_p0_we), .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata),
      .o_p0_ack(o_p0_ack), .o_p0_done(o_p0_done), .o_p0_rdata(o_p0_rdata),
      .i_p1_req(i_p1_req), .i_p1_addr(i_p1_addr),
      .o_p1_ack(o_p1_ack), .o_p1_done(o_p1_done), .o_p1_busy(o_p1_busy), .o_p1_rdata(o_p1_rdata),
      .o_mc_start(o_mc_start), .o_mc_write_en(o_mc_write_en), .o_mc_burst_en(o_mc_burst_en),
      .o_mc_addr(o_mc_addr), .o_mc_data_in(o_mc_data_in),
      .i_mc_data_out(i_mc_data_out), .i_mc_data_ready(i_mc_data_ready),
      .i_mc_mem_ready(i_mc_mem_ready), .o_err(o_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          m_last;
   logic        m_err;
   logic [15:0] m_p0_rdata;
   logic [15:0] m_mem [logic [24:0]];

   // Pending requester commands
   logic        pend0, pend1, c0_we;
   logic [24:0] c0_addr, c1_addr;
   logic [15:0] c0_wdata;
   int          last_port_seen;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic new_p0_cmd();
      pend0    = 1'b1;
      c0_we    = 1'($urandom_range(0, 1));
      c0_addr  = 25'($urandom_range(0, 7));
      c0_wdata = 16'($urandom);
   endtask

   task automatic new_p1_cmd();
      pend1   = 1'b1;
      c1_addr = 25'($urandom);
   endtask

   // mode 0: normal controller, 1: never goes busy, 2: busy forever.
   // Called and returns at a falling edge.
   task automatic do_txn(input int mode, input int exp_ack_lat);
      int          exp_port, got_port, cyc, lat, exp_lat, L;
      logic        exp_e, exp_we, exp_burst, is_rd0, seen_done;
      logic [24:0] exp_addr;
      logic [15:0] exp_din, rd_word;
      i_p0_req = pend0; i_p0_we = c0_we; i_p0_addr = c0_addr; i_p0_wdata = c0_wdata;
      i_p1_req = pend1; i_p1_addr = c1_addr;
      if (!pend0 && !pend1) return;
      exp_port = (pend0 && pend1) ? (1 - m_last) : (pend1 ? 1 : 0);
      if (exp_port == 0) begin
         exp_we = c0_we; exp_burst = 1'b0; exp_addr = c0_addr; exp_din = c0_wdata;
      end else begin
         exp_we = 1'b0; exp_burst = 1'b1; exp_addr = c1_addr; exp_din = 16'h0;
      end
      is_rd0  = (exp_port == 0) && !c0_we;
      rd_word = m_mem.exists(c0_addr) ? m_mem[c0_addr] : 16'($urandom);

      cyc = 0;
      while (!(o_p0_ack || o_p1_ack) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 50) begin
         check_value("ack_wait", 32'd0, 32'd1);
         return;
      end
      if (exp_ack_lat >= 0) check_value("ack_latency", cyc, exp_ack_lat);
      got_port = o_p1_ack ? 1 : 0;
      check_value("grant_port", got_port, exp_port);
      check_value("mc_start", o_mc_start, 1);
      check_value("mc_write_en", o_mc_write_en, exp_we);
      check_value("mc_burst_en", o_mc_burst_en, exp_burst);
      check_value("mc_addr", o_mc_addr, exp_addr);
      check_value("mc_data_in", o_mc_data_in, exp_din);
      if (got_port == 0) begin i_p0_req = 1'b0; pend0 = 1'b0; end
      else begin i_p1_req = 1'b0; pend1 = 1'b0; end

      L = 0;
      case (mode)
         1:       begin exp_lat = BUSY_TO;     exp_e = 1'b1; end
         2:       begin exp_lat = 2 + DONE_TO; exp_e = 1'b1; end
         default: begin
            L = (exp_port == 1) ? int'($urandom_range(4, 10)) : (c0_we ? 2 : 3);
            exp_lat = L + 2; exp_e = 1'b0;
         end
      endcase

      seen_done = 1'b0;
      lat = 0;
      for (int k = 1; k <= exp_lat + 10 && !seen_done; k++) begin
         @(posedge clk);
         #1;
         if (mode == 0) begin
            if (k <= L) begin
               i_mc_data_ready = 1'b0;
               i_mc_data_out   = 16'($urandom);
            end else begin
               i_mc_data_ready = 1'b1;
               if (is_rd0) i_mc_data_out = rd_word;
            end
         end else if (mode == 2) begin
            i_mc_data_ready = 1'b0;
         end
         @(negedge clk);
         if (k == 1) begin
            check_value("ack_one_cycle", o_p0_ack | o_p1_ack, 0);
            check_value("start_one_cycle", o_mc_start, 0);
            check_value("p1_busy_during", o_p1_busy, (exp_port == 1) ? 1 : 0);
         end
         if (k == 2 && mode == 0 && exp_port == 1)
            check_value("p1_rdata_pass", o_p1_rdata, i_mc_data_out);
         if (o_p0_done || o_p1_done) begin
            seen_done = 1'b1;
            lat = k;
         end
      end
      i_mc_data_ready = 1'b1;

      if (mode == 0 && exp_port == 0) begin
         if (c0_we) m_mem[c0_addr] = c0_wdata;
         else       m_p0_rdata = rd_word;
      end
      m_err  = m_err | exp_e;
      m_last = exp_port;

      check_value("done_latency", lat, exp_lat);
      check_value("done_port", {o_p1_done, o_p0_done}, (exp_port == 1) ? 2'b10 : 2'b01);
      check_value("p0_rdata", o_p0_rdata, m_p0_rdata);
      check_value("err", o_err, m_err);
      check_value("p1_busy_at_done", o_p1_busy, 0);
      @(negedge clk);
      check_value("done_one_cycle", o_p0_done | o_p1_done, 0);
      last_port_seen = got_port;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, mode;
      logic [3:0] hist;
      rst = 1'b0;
      i_p0_req = 1'b0; i_p0_we = 1'b0; i_p0_addr = '0; i_p0_wdata = '0;
      i_p1_req = 1'b0; i_p1_addr = '0;
      i_mc_data_out = '0; i_mc_data_ready = 1'b1; i_mc_mem_ready = 1'b0;
      m_last = 1; m_err = 1'b0; m_p0_rdata = '0;
      pend0 = 1'b0; pend1 = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0; c1_addr = '0;
      last_port_seen = 0;
      repeat (3) @(negedge clk);
      check_value("rst_flags", {o_p0_ack, o_p0_done, o_p1_ack, o_p1_done, o_p1_busy,
                                o_mc_start, o_mc_write_en, o_mc_burst_en, o_err}, 0);
      check_value("rst_mc_addr", o_mc_addr, 0);
      check_value("rst_mc_data_in", o_mc_data_in, 0);
      check_value("rst_p0_rdata", o_p0_rdata, 0);

      // Controller not initialised: request must wait.
      rst = 1'b1;
      pend0 = 1'b1; c0_we = 1'b1; c0_addr = 25'h0000123; c0_wdata = 16'hBEEF;
      i_p0_req = 1'b1; i_p0_we = c0_we; i_p0_addr = c0_addr; i_p0_wdata = c0_wdata;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_p0_ack || o_p1_ack) cnt++;
      end
      check_value("no_ack_in_init", cnt, 0);
      i_mc_mem_ready = 1'b1;
      do_txn(0, 2);

      // Read back the written word.
      pend0 = 1'b1; c0_we = 1'b0; c0_addr = 25'h0000123;
      do_txn(0, -1);
      check_value("read_beef", o_p0_rdata, 16'hBEEF);

      // Controller never goes busy, then normal service with sticky err.
      new_p0_cmd();
      do_txn(1, -1);
      new_p0_cmd();
      do_txn(0, -1);
      // Controller goes busy and never finishes.
      new_p1_cmd();
      do_txn(2, -1);

      // Reset in the middle of a burst.
      new_p1_cmd();
      i_p1_req = 1'b1; i_p1_addr = c1_addr;
      cnt = 0;
      while (!o_p1_ack && cnt < 20) begin @(negedge clk); cnt++; end
      check_value("rst_test_ack", o_p1_ack, 1);
      i_p1_req = 1'b0; pend1 = 1'b0;
      @(posedge clk); #1 i_mc_data_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_value("busy_before_rst", o_p1_busy, 1);
      rst = 1'b0;
      cnt = 0;
      @(negedge clk);
      check_value("rst_p1_busy", o_p1_busy, 0);
      check_value("rst_mc_start", o_mc_start, 0);
      check_value("rst_err", o_err, 0);
      check_value("rst_p0_rdata2", o_p0_rdata, 0);
      i_mc_mem_ready = 1'b0; i_mc_data_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (o_p1_done) cnt++;
      end
      rst = 1'b1;
      m_last = 1; m_err = 1'b0; m_p0_rdata = '0;

      // Back in INIT: both ports request, nothing granted until ready.
      new_p0_cmd();
      new_p1_cmd();
      i_p0_req = 1'b1; i_p0_we = c0_we; i_p0_addr = c0_addr; i_p0_wdata = c0_wdata;
      i_p1_req = 1'b1; i_p1_addr = c1_addr;
      repeat (5) begin
         @(negedge clk);
         if (o_p0_ack || o_p1_ack || o_p1_done) cnt++;
      end
      check_value("no_done_no_ack_after_rst", cnt, 0);
      i_mc_mem_ready = 1'b1;

      // Continuous requests from both ports alternate.
      hist = '0;
      for (int i = 0; i < 4; i++) begin
         do_txn(0, -1);
         hist[i] = last_port_seen[0];
         if (!pend0) new_p0_cmd();
         if (!pend1) new_p1_cmd();
      end
      check_value("alt_seq", hist, 4'b1010);

      // Randomized traffic.
      for (int i = 0; i < 30; i++) begin
         if (!pend0 && $urandom_range(0, 9) < 6) new_p0_cmd();
         if (!pend1 && $urandom_range(0, 9) < 4) new_p1_cmd();
         if (!pend0 && !pend1) new_p0_cmd();
         mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
         do_txn(mode, -1);
      end
      while (pend0 || pend1) do_txn(0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
